uart_tx_word_arbiter: RTL

//   Shares one byte-wide UART transmitter among NUM_REQ word-producing clients.

---
 rtl/uart_word_pkg.sv | 20 ++
 rtl/uart_tx_word_arbiter_if.sv | 31 +++
 rtl/uart_tx_word_arbiter_rr_arbiter.sv | 35 +++
 rtl/uart_tx_word_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/uart_word_pkg.sv
// Shared types and sizing helpers for the UART word chain (TX arbiter, word_join).
package uart_word_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } tx_arb_state_t;

  // Number of UART parts that make up one client word.
  function automatic int unsigned parts(input int unsigned word_size,
                                        input int unsigned word_part);
    return word_size / word_part;
  endfunction

  // Width of a counter indexing the parts of a word; never narrower than 1 bit.
  function automatic int unsigned part_cnt_width(input int unsigned num_parts);
    return (num_parts <= 1) ? 1 : $clog2(num_parts);
  endfunction

endpackage

// File: rtl/uart_tx_word_arbiter_if.sv
// Client word handshake plus byte-wide uart_tx handshake for the TX word arbiter.
interface uart_tx_word_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned WORD_PART = 8
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [WORD_PART-1:0]         tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [IDX_W-1:0]             grant_id;
  logic                         busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy
  );

  // Clients and uart_tx side.
  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_word_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_req
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned idx;
  logic        found;

  // Scan from last_grant+1 upward; last_grant itself is visited last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter sharing one byte-wide uart_tx among word-producing clients;
// the granted word is serialised least-significant part first.
module uart_tx_word_arbiter
  import uart_word_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned WORD_PART = 8
) (
  input logic                    clock,
  input logic                    reset,
  uart_tx_word_arbiter_if.master bus
);

  localparam int unsigned PARTS = parts(WORD_SIZE, WORD_PART);
  localparam int unsigned CNT_W = part_cnt_width(PARTS);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (WORD_SIZE % WORD_PART != 0) begin : g_bad_word
    $error("uart_tx_word_arbiter: WORD_SIZE must be a multiple of WORD_PART");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("uart_tx_word_arbiter: NUM_REQ must be at least 2");
  end

  tx_arb_state_t        state_q, state_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     part_cnt_q, part_cnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  // State and datapath registers; reset restarts priority at client 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      part_cnt_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      part_cnt_q   <= part_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  // Next-state, word capture, part serialisation and handshake outputs.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    part_cnt_d    = part_cnt_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    bus.req_ready = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          bus.req_ready = arb_grant;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
              shift_d = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
            end
          end
          grant_id_d   = arb_idx;
          last_grant_d = arb_idx;
          part_cnt_d   = '0;
          state_d      = SEND;
        end
      end
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.busy     = 1'b1;
        bus.tx_data  = shift_q[WORD_PART-1:0];
        if (bus.tx_ready) begin
          shift_d = shift_q >> WORD_PART;
          if (part_cnt_q == CNT_W'(PARTS - 1)) begin
            part_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            part_cnt_d = part_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant_id = grant_id_q;

endmodule
